// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32x32 multiply / divide sequencer that owns HI/LO.
// One multiplier or quotient bit per cycle. A launch on edge E0 writes HI/LO
// on E33, and done pulses in the cycle after that edge.
// Build option: define MDU_DIV_EN to compile the DIV/DIVU datapath. Without
// it, a divide start is ignored.
module mdu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        accept;
  logic        op_ok;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  // Multiplicand for multiply, divisor for divide.
  logic [31:0] addend;
  // Multiply: {partial sum, remaining multiplier bits}. Divide: [31:0] holds
  // the dividend shifting out and the quotient shifting in.
  logic [63:0] prod;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;
`ifdef MDU_DIV_EN
  logic        is_div;
  logic        div_zero;
  logic [32:0] rem;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
`endif

  // A divide request is accepted only when the divide datapath is built.
`ifdef MDU_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif
  assign accept = start && (state == IDLE) && op_ok;
  assign busy   = (state != IDLE);

  // Operand magnitudes. op[0]=0 selects the signed variants.
  assign mag_a = (!op[0] && opA[31]) ? (~opA + 32'd1) : opA;
  assign mag_b = (!op[0] && opB[31]) ? (~opB + 32'd1) : opB;

  // Radix-2 shift-add step. The carry out of the add becomes product bit 63.
  assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, addend} : 33'd0);
  assign mul_next = {mul_sum, prod[31:1]};

`ifdef MDU_DIV_EN
  // Restoring divide step. The remainder stays below the divisor, so a
  // non-negative difference fits in 32 bits. Bit 32 is therefore the borrow.
  assign div_shift = {rem[31:0], prod[31]};
  assign div_diff  = div_shift - {1'b0, addend};
  assign rem_next  = div_diff[32] ? div_shift : div_diff;
  assign quo_next  = {prod[30:0], ~div_diff[32]};
`endif

  // Final sign fix-up and HI/LO selection, applied in SIGN.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    prod_fix = (neg_a ^ neg_b) ? (~prod + 64'd1) : prod;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
`ifdef MDU_DIV_EN
    quo_fix = (neg_a ^ neg_b) ? (~prod[31:0] + 32'd1) : prod[31:0];
    rem_fix = neg_a ? (~rem[31:0] + 32'd1) : rem[31:0];
    if (is_div) begin
      // With a zero divisor every quotient bit comes out 1, and the remainder
      // holds the dividend. Only a signed negative dividend would flip the
      // quotient, so LO is forced to all ones.
      res_hi = rem_fix;
      res_lo = div_zero ? 32'hFFFF_FFFF : quo_fix;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. After counter value 31 the sequencer goes to SIGN.
  // A flush abandons CALC or SIGN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == 6'd31) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands at launch, then iterate once per CALC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= 6'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      addend <= 32'd0;
      prod   <= 64'd0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      rem      <= 33'd0;
`endif
    end else if (accept) begin
      cnt   <= 6'd0;
      neg_a <= ~op[0] & opA[31];
      neg_b <= ~op[0] & opB[31];
`ifdef MDU_DIV_EN
      is_div   <= op[1];
      div_zero <= (opB == 32'd0);
      rem      <= 33'd0;
      if (op[1]) begin
        addend <= mag_b;
        prod   <= {32'd0, mag_a};
      end else begin
        addend <= mag_a;
        prod   <= {32'd0, mag_b};
      end
`else
      addend <= mag_a;
      prod   <= {32'd0, mag_b};
`endif
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
`ifdef MDU_DIV_EN
      if (is_div) begin
        prod[31:0] <= quo_next;
        rem        <= rem_next;
      end else begin
        prod <= mul_next;
      end
`else
      prod <= mul_next;
`endif
    end
  end

  // HI/LO: the result is written in SIGN unless flushed. MTHI/MTLO writes
  // apply only in IDLE, and an accepted start takes priority over them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (state == SIGN && !flush) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == IDLE && !accept) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  // Completion pulse, raised in the cycle after HI/LO were written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == SIGN) && !flush;
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: table-driven vectors for mdu_seq, plus hand-written sequences
// for flush, MTHI racing start, back-to-back launch and reset mid-operation.
// Divide expectations depend on whether MDU_DIV_EN is defined.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA, opB;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  mdu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[15];
  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Called at a negedge. Applies start for one edge and returns at the next negedge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the launch edge. Waits, with a bound, for busy
  // to drop. Returns at the negedge where done should be high.
  task automatic wait_result(input string name, input logic [31:0] pre_hi, input logic [31:0] pre_lo);
    int  cyc;
    bit  stable;
    cyc = 0;
    stable = 1'b1;
    while (busy === 1'b1 && cyc < 100) begin
      if (done !== 1'b0 || hi !== pre_hi || lo !== pre_lo) stable = 1'b0;
      cyc++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, cyc, 33);
    check({name, " stable_while_busy"}, stable, 1);
    check({name, " done_pulse"}, done, 1);
  endtask

  // Watches for a number of cycles and checks that neither busy nor done appears.
  task automatic expect_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check({name, " quiet"}, seen, 0);
  endtask

  initial begin
    vecs[0]  = '{"mult_m1x2",     MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{"multu_m1x2",    MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{"div_m7_2",      DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"multu_10x3",    MULTU, 32'd10,        32'd3,         32'd0,         32'd30};
    vecs[4]  = '{"divu_5_0",      DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5]  = '{"mult_max_sq",   MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[6]  = '{"div_min_m1",    DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[7]  = '{"mult_min_sq",   MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{"divu_10_3",     DIVU,  32'd10,        32'd3,         32'd1,         32'd3};
    vecs[9]  = '{"mult_m3x5",     MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[10] = '{"div_7_m2",      DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[11] = '{"multu_max",     MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[12] = '{"div_m5_0",      DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[13] = '{"mult_0x12345",  MULT,  32'd0,         32'd12345,     32'd0,         32'd0};
    vecs[14] = '{"divu_max_1",    DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    lo_we = 1'b0;
    m_hi = 32'h1234; m_lo = 32'h55;
    check("mthi", hi, m_hi);
    check("mtlo", lo, m_lo);

    // MULT 3x4 is flushed before it finishes. A start and an MTHI strobe
    // during busy are ignored.
    launch(MULT, 32'd3, 32'd4);
    check("flush_seq busy", busy, 1);
    repeat (4) @(negedge clk);
    op = MULTU; opA = 32'd9; opB = 32'd9; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("start_while_busy hi", hi, m_hi);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", busy, 0);
    check("flush done", done, 0);
    expect_quiet("after_flush", 40);
    check("flush hi", hi, m_hi);
    check("flush lo", lo, m_lo);

    // Table-driven operations.
    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].op[1] && !DIV_EN) begin
        expect_quiet(vecs[i].name, 40);
      end else begin
        check({vecs[i].name, " busy_after_launch"}, busy, 1);
        wait_result(vecs[i].name, m_hi, m_lo);
        m_hi = vecs[i].exp_hi;
        m_lo = vecs[i].exp_lo;
        @(negedge clk);
        check({vecs[i].name, " done_one_cycle"}, done, 0);
      end
      check({vecs[i].name, " hi"}, hi, m_hi);
      check({vecs[i].name, " lo"}, lo, m_lo);
    end

    // A start in the same cycle as hi_we: the write is dropped.
    hi_we = 1'b1; wdata = 32'hBEEF;
    launch(MULTU, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("start_vs_mthi hi_kept", hi, m_hi);
    check("start_vs_mthi busy", busy, 1);
    wait_result("start_vs_mthi", m_hi, m_lo);
    m_hi = 32'd0; m_lo = 32'd6;
    check("start_vs_mthi hi", hi, m_hi);
    check("start_vs_mthi lo", lo, m_lo);

    // Back-to-back: a new start is accepted in the cycle where done is high.
    launch(MULTU, 32'd6, 32'd7);
    wait_result("b2b_first", m_hi, m_lo);
    m_lo = 32'd42;
    check("b2b_first lo", lo, m_lo);
    launch(MULTU, 32'd2, 32'd2);
    check("b2b_second busy", busy, 1);
    wait_result("b2b_second", m_hi, m_lo);
    m_lo = 32'd4;
    check("b2b_second lo", lo, m_lo);

    // Reset mid-operation clears everything immediately.
    launch(MULT, 32'd100, 32'd100);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_mid busy", busy, 0);
    check("reset_mid hi", hi, 0);
    check("reset_mid lo", lo, 0);
    check("reset_mid done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("after_reset", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
